put_get_buffer: RTL and testbench



---
 rtl/put_get_pkg.sv | 12 +
 rtl/put_get_buffer_mem.sv | 24 ++
 rtl/put_get_buffer.sv | 103 ++++++++++
 tb/tb_put_get_buffer.sv | 137 +++++++++++++
 4 files changed

// File: rtl/put_get_pkg.sv
// Shared definitions for put_get_buffer: pointer width helper and pointer reset values.
package put_get_pkg;

    // One extra MSB beyond the address bits distinguishes full from empty.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned WP_RST = 0;
    localparam int unsigned RP_RST = 0;

endpackage

// File: rtl/put_get_buffer_mem.sv
// DEPTH x DATA_WIDTH storage array: one synchronous write port, one asynchronous read port.
module put_get_buffer_mem #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]      rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/put_get_buffer.sv
// Registered elastic buffer converting a Put interface to a Get interface; RDY outputs depend only on state.
// Optional sticky protocol-error flag enabled by defining PUT_GET_BUFFER_ERR_EN.
module put_get_buffer
    import put_get_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     put,
    input  logic                      EN_put,
    output logic                      RDY_put,
    output logic [DATA_WIDTH-1:0]     get,
    input  logic                      EN_get,
    output logic                      RDY_get,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      proto_err
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned AW = PW - 1;

    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic          full, empty;
    logic          put_fire, get_fire;

    assign empty = (wp_q == rp_q);
    assign full  = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[PW-1] != rp_q[PW-1]);

    assign RDY_put = !full;
    assign RDY_get = !empty;
    assign count   = wp_q - rp_q;

    assign put_fire = EN_put && !full;
    assign get_fire = EN_get && !empty;

    always_comb begin
        wp_d = wp_q;
        rp_d = rp_q;
        if (put_fire) begin
            wp_d = wp_q + PW'(1);
        end
        if (get_fire) begin
            rp_d = rp_q + PW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wp_q <= PW'(WP_RST);
            rp_q <= PW'(RP_RST);
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    put_get_buffer_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (CLK),
        .we    (put_fire),
        .waddr (wp_q[AW-1:0]),
        .wdata (put),
        .raddr (rp_q[AW-1:0]),
        .rdata (get)
    );

`ifdef PUT_GET_BUFFER_ERR_EN
    logic err_q, err_d;
    logic put_viol, get_viol;

    assign put_viol = EN_put && full;
    assign get_viol = EN_get && empty;

    always_comb begin
        err_d = err_q | put_viol | get_viol;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge CLK) begin
        if (!RST && put_viol) $display("put_get_buffer %m: EN_put asserted while full");
        if (!RST && get_viol) $display("put_get_buffer %m: EN_get asserted while empty");
    end
`endif

    assign proto_err = err_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_put_get_buffer.sv
// Directed, table-driven bench for put_get_buffer (DEPTH=4 table, DEPTH=2 streaming).
module tb_put_get_buffer;

`ifdef PUT_GET_BUFFER_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic       CLK = 1'b0;
    always #5 CLK = ~CLK;

    // DEPTH = 4 instance
    logic       rst4, ep4, eg4;
    logic [7:0] pd4;
    logic       rp4, rg4, pe4;
    logic [7:0] g4;
    logic [2:0] c4;

    // DEPTH = 2 instance
    logic       rst2, ep2, eg2;
    logic [7:0] pd2;
    logic       rp2, rg2, pe2;
    logic [7:0] g2;
    logic [1:0] c2;

    put_get_buffer #(.DATA_WIDTH(8), .DEPTH(4)) u4 (
        .CLK(CLK), .RST(rst4), .put(pd4), .EN_put(ep4), .RDY_put(rp4),
        .get(g4), .EN_get(eg4), .RDY_get(rg4), .count(c4), .proto_err(pe4)
    );

    put_get_buffer #(.DATA_WIDTH(8), .DEPTH(2)) u2 (
        .CLK(CLK), .RST(rst2), .put(pd2), .EN_put(ep2), .RDY_put(rp2),
        .get(g2), .EN_get(eg2), .RDY_get(rg2), .count(c2), .proto_err(pe2)
    );

    typedef struct {
        bit       rst;
        bit       ep;
        bit [7:0] pd;
        bit       eg;
        bit       xrp;
        bit       xrg;
        int       xc;
        bit [7:0] xg;
        bit       xerr;
    } vec_t;

    vec_t vt[19];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        //          rst ep  pd     eg  rdyp rdyg cnt get    err
        vt[0]  = '{1, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0};
        vt[1]  = '{0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0};
        vt[2]  = '{0, 1, 8'h01, 0, 1, 1, 1, 8'h01, 0};
        vt[3]  = '{0, 1, 8'h02, 0, 1, 1, 2, 8'h01, 0};
        vt[4]  = '{0, 1, 8'h03, 0, 1, 1, 3, 8'h01, 0};
        vt[5]  = '{0, 1, 8'h04, 0, 0, 1, 4, 8'h01, 0};
        vt[6]  = '{0, 1, 8'h05, 0, 0, 1, 4, 8'h01, ERR};   // ignored put while full
        vt[7]  = '{0, 1, 8'h09, 1, 1, 1, 3, 8'h02, ERR};   // full: get only
        vt[8]  = '{0, 0, 8'h00, 1, 1, 1, 2, 8'h03, ERR};
        vt[9]  = '{0, 0, 8'h00, 1, 1, 1, 1, 8'h04, ERR};
        vt[10] = '{0, 0, 8'h00, 1, 1, 0, 0, 8'h00, ERR};
        vt[11] = '{0, 0, 8'h00, 1, 1, 0, 0, 8'h00, ERR};   // get while empty
        vt[12] = '{0, 1, 8'h11, 1, 1, 1, 1, 8'h11, ERR};   // empty: put only
        vt[13] = '{0, 1, 8'h22, 1, 1, 1, 1, 8'h22, ERR};   // count 1, both
        vt[14] = '{0, 1, 8'h33, 0, 1, 1, 2, 8'h22, ERR};
        vt[15] = '{0, 1, 8'h44, 0, 1, 1, 3, 8'h22, ERR};
        vt[16] = '{1, 1, 8'h55, 0, 1, 0, 0, 8'h00, 0};     // reset mid-operation
        vt[17] = '{0, 1, 8'h7E, 0, 1, 1, 1, 8'h7E, 0};
        vt[18] = '{0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0};

        rst4 = 1'b1; ep4 = 1'b0; eg4 = 1'b0; pd4 = '0;
        rst2 = 1'b1; ep2 = 1'b0; eg2 = 1'b0; pd2 = '0;
        @(posedge CLK); #1;
        rst2 = 1'b0;

        for (int i = 0; i < 19; i++) begin
            rst4 = vt[i].rst; ep4 = vt[i].ep; pd4 = vt[i].pd; eg4 = vt[i].eg;
            @(posedge CLK); #1;
            chk($sformatf("row%0d RDY_put", i), int'(rp4), int'(vt[i].xrp));
            chk($sformatf("row%0d RDY_get", i), int'(rg4), int'(vt[i].xrg));
            chk($sformatf("row%0d count", i), int'(c4), vt[i].xc);
            chk($sformatf("row%0d proto_err", i), int'(pe4), int'(vt[i].xerr));
            if (vt[i].xrg) chk($sformatf("row%0d get", i), int'(g4), int'(vt[i].xg));
        end
        rst4 = 1'b0; ep4 = 1'b0; eg4 = 1'b0;

        // Streaming on DEPTH=2: put and get every cycle, 120 words (>25 pointer wraps).
        chk("stream idle RDY_get", int'(rg2), 0);
        chk("stream idle count", int'(c2), 0);
        for (int i = 0; i < 120; i++) begin
            ep2 = 1'b1; eg2 = 1'b1; pd2 = 8'(i * 7 + 3);
            @(posedge CLK); #1;
            chk($sformatf("stream%0d get", i), int'(g2), (i * 7 + 3) & 8'hFF);
            chk($sformatf("stream%0d count", i), int'(c2), 1);
            chk($sformatf("stream%0d RDY_get", i), int'(rg2), 1);
            chk($sformatf("stream%0d RDY_put", i), int'(rp2), 1);
        end
        ep2 = 1'b0; eg2 = 1'b1;
        @(posedge CLK); #1;
        chk("stream drain count", int'(c2), 0);
        chk("stream drain RDY_get", int'(rg2), 0);
        chk("stream proto_err", int'(pe2), int'(ERR));  // first cycle got on empty
        eg2 = 1'b0;

        // DEPTH=2 fill to full, then reset clears flag and occupancy.
        ep2 = 1'b1; pd2 = 8'hC1;
        @(posedge CLK); #1;
        pd2 = 8'hC2;
        @(posedge CLK); #1;
        ep2 = 1'b0;
        chk("d2 full count", int'(c2), 2);
        chk("d2 full RDY_put", int'(rp2), 0);
        chk("d2 full get", int'(g2), 8'hC1);
        rst2 = 1'b1;
        @(posedge CLK); #1;
        rst2 = 1'b0;
        chk("d2 rst count", int'(c2), 0);
        chk("d2 rst RDY_put", int'(rp2), 1);
        chk("d2 rst proto_err", int'(pe2), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
